// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes active-low columns, synchronises the rows,
// classifies each full scan frame and debounces presses/releases into key events.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    function automatic logic [3:0] key_map(input logic [1:0] col, input logic [1:0] row);
        logic [3:0] code;
        case ({col, row})
            4'h0: code = 4'h1;
            4'h1: code = 4'h4;
            4'h2: code = 4'h7;
            4'h3: code = 4'h0;
            4'h4: code = 4'h2;
            4'h5: code = 4'h5;
            4'h6: code = 4'h8;
            4'h7: code = 4'hF;
            4'h8: code = 4'h3;
            4'h9: code = 4'h6;
            4'hA: code = 4'h9;
            4'hB: code = 4'hE;
            4'hC: code = 4'hA;
            4'hD: code = 4'hB;
            4'hE: code = 4'hC;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    logic [3:0]       r_sync1, r_sync2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic [1:0]       r_hits;
    logic [3:0]       r_acc_key;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_cand;

    logic [3:0]       w_pressed;
    logic [2:0]       w_col_hits;
    logic [1:0]       w_row_idx;
    logic [1:0]       w_col_next;
    logic             w_sample;
    logic             w_eval;
    logic [1:0]       w_frame_hits;
    logic [3:0]       w_frame_key;
    logic             w_is_none, w_is_key, w_is_multi;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_pressed  = ~r_sync2;
    assign w_col_hits = {2'b00, w_pressed[0]} + {2'b00, w_pressed[1]}
                      + {2'b00, w_pressed[2]} + {2'b00, w_pressed[3]};
    assign w_sample   = (r_div == DIV_LAST);
    assign w_eval     = w_sample && (r_col == 2'd3);
    assign w_col_next = r_col + 2'd1;
    assign w_cnt_inc  = r_cnt + CNT_ONE;

    // Row index of the single pressed row in the current column
    always_comb begin
        w_row_idx = 2'd0;
        if (w_pressed[1]) begin
            w_row_idx = 2'd1;
        end else if (w_pressed[2]) begin
            w_row_idx = 2'd2;
        end else if (w_pressed[3]) begin
            w_row_idx = 2'd3;
        end else begin
            w_row_idx = 2'd0;
        end
    end

    // Merge this column's sample into the running frame result (hits saturate at 2 = MULTI)
    always_comb begin
        w_frame_hits = r_hits;
        w_frame_key  = r_acc_key;
        if (w_col_hits == 3'd0) begin
            w_frame_hits = r_hits;
        end else if ((w_col_hits == 3'd1) && (r_hits == 2'd0)) begin
            w_frame_hits = 2'd1;
            w_frame_key  = key_map(r_col, w_row_idx);
        end else begin
            w_frame_hits = 2'd2;
        end
    end

    assign w_is_none  = (w_frame_hits == 2'd0);
    assign w_is_key   = (w_frame_hits == 2'd1);
    assign w_is_multi = (w_frame_hits == 2'd2);

    // Row synchroniser, column strobe divider and per-frame accumulation
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= 4'hF;
            r_sync2   <= 4'hF;
            r_div     <= '0;
            r_col     <= 2'd0;
            col_n     <= 4'b1110;
            r_hits    <= 2'd0;
            r_acc_key <= 4'h0;
        end else begin
            r_sync1 <= row_n;
            r_sync2 <= r_sync1;
            if (w_sample) begin
                r_div <= '0;
                r_col <= w_col_next;
                col_n <= ~(4'b0001 << w_col_next);
                if (r_col == 2'd3) begin
                    r_hits    <= 2'd0;
                    r_acc_key <= 4'h0;
                end else begin
                    r_hits    <= w_frame_hits;
                    r_acc_key <= w_frame_key;
                end
            end else begin
                r_div <= r_div + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Press/release debounce FSM, advanced once per frame at the column-3 sample
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cand    <= 4'h0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (w_eval) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_is_key) begin
                            r_cand <= w_frame_key;
                            if (CNT_ONE >= CNT_DONE) begin
                                r_state   <= S_PRESSED;
                                r_cnt     <= '0;
                                key_code  <= w_frame_key;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                r_state <= S_DEBOUNCE;
                                r_cnt   <= CNT_ONE;
                            end
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (w_is_key && (w_frame_key == r_cand)) begin
                            if (w_cnt_inc >= CNT_DONE) begin
                                r_state   <= S_PRESSED;
                                r_cnt     <= '0;
                                key_code  <= r_cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else if (w_is_key) begin
                            r_cand <= w_frame_key;
                            r_cnt  <= CNT_ONE;
                        end else begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    S_PRESSED: begin
                        if (w_is_multi || (w_is_key && (w_frame_key == key_code))) begin
                            r_cnt <= '0;
                        end else if (CNT_ONE >= CNT_DONE) begin
                            r_state  <= S_IDLE;
                            r_cnt    <= '0;
                            key_held <= 1'b0;
                        end else begin
                            r_state <= S_RELEASE;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                    S_RELEASE: begin
                        if (w_is_multi || (w_is_key && (w_frame_key == key_code))) begin
                            r_state <= S_PRESSED;
                            r_cnt   <= '0;
                        end else if (w_cnt_inc >= CNT_DONE) begin
                            r_state  <= S_IDLE;
                            r_cnt    <= '0;
                            key_held <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end else begin
                r_state <= r_state;
            end
        end
    end

    logic w_unused;
    assign w_unused = w_is_none;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows from col_n,
// expected key events are queued at stimulus time and matched by a monitor.
module tb_keypad_scanner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = 16'h0000;
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] code;
        int         lo;
        int         hi;
    } exp_t;
    exp_t q[$];

    keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_SCANS(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Keypad model: a pressed key pulls its row low while its column is strobed
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4+r] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    function automatic int kidx(input int c, input int r);
        return c * 4 + r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input logic [3:0] code, input int lo, input int hi);
        exp_t e;
        e.code = code;
        e.lo   = cyc + lo;
        e.hi   = cyc + hi;
        q.push_back(e);
    endtask

    task automatic wait_frame_start();
        logic [3:0] prev;
        logic       found;
        prev  = col_n;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clock);
            if (col_n == 4'b1110 && prev == 4'b0111) found = 1'b1;
            prev = col_n;
        end
        check("frame_start_seen", {31'd0, found}, 32'd1);
    endtask

    task automatic wait_valid(input int bound);
        logic found;
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clock);
            if (key_valid) found = 1'b1;
        end
        check("valid_seen", {31'd0, found}, 32'd1);
    endtask

    // Monitor: every key_valid pulse must match the oldest queued expectation
    always @(negedge clock) begin
        exp_t e;
        if (key_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: key_code=%0h at cycle %0d, none expected", key_code, cyc);
            end else begin
                e = q.pop_front();
                check("pulse_code", {28'd0, key_code}, {28'd0, e.code});
                checks++;
                if (cyc < e.lo || cyc > e.hi) begin
                    failures++;
                    $display("FAIL pulse_latency: cycle %0d expected %0d..%0d", cyc, e.lo, e.hi);
                end
            end
        end
    end

    initial begin
        logic [3:0] exp_col;
        logic       held_ok;

        // 1. reset values and column walk
        tick(2);
        check("rst_col_n", {28'd0, col_n}, 32'hE);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_held", {31'd0, key_held}, 32'd0);
        check("rst_code", {28'd0, key_code}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 64; k++) begin
            exp_col = ~(4'b0001 << ((k / 8) % 4));
            check("col_walk", {28'd0, col_n}, {28'd0, exp_col});
            tick(1);
        end

        // 2. clean press of 5 aligned to a frame start
        wait_frame_start();
        keys[kidx(1, 1)] = 1'b1;
        push(4'h5, 96, 131);
        tick(299);
        check("t2_held", {31'd0, key_held}, 32'd1);
        check("t2_code", {28'd0, key_code}, 32'h5);
        keys = 16'h0000;
        tick(160);
        check("t2_released", {31'd0, key_held}, 32'd0);
        check("t2_code_kept", {28'd0, key_code}, 32'h5);

        // 3. bouncing 9, then a stable hold
        for (int i = 0; i < 3; i++) begin
            keys[kidx(2, 2)] = 1'b1;
            tick(40);
            keys = 16'h0000;
            tick(40);
        end
        check("t3_no_hold_bounce", {31'd0, key_held}, 32'd0);
        keys[kidx(2, 2)] = 1'b1;
        push(4'h9, 64, 140);
        tick(200);
        check("t3_held", {31'd0, key_held}, 32'd1);
        check("t3_code", {28'd0, key_code}, 32'h9);
        keys = 16'h0000;
        tick(160);
        check("t3_released", {31'd0, key_held}, 32'd0);

        // 4. two keys from idle, then a second key while 5 is held
        keys[kidx(0, 0)] = 1'b1;
        keys[kidx(1, 0)] = 1'b1;
        tick(200);
        check("t4_multi_held", {31'd0, key_held}, 32'd0);
        keys = 16'h0000;
        tick(40);
        keys[kidx(1, 1)] = 1'b1;
        push(4'h5, 64, 140);
        tick(150);
        check("t4_held5", {31'd0, key_held}, 32'd1);
        keys[kidx(3, 3)] = 1'b1;
        tick(150);
        check("t4_code_still5", {28'd0, key_code}, 32'h5);
        check("t4_held_with_d", {31'd0, key_held}, 32'd1);
        keys = 16'h0000;
        tick(160);
        check("t4_released", {31'd0, key_held}, 32'd0);

        // 5. short drop of F while held, then a full release
        keys[kidx(1, 3)] = 1'b1;
        push(4'hF, 64, 140);
        tick(150);
        check("t5_held", {31'd0, key_held}, 32'd1);
        held_ok = 1'b1;
        keys = 16'h0000;
        for (int i = 0; i < 32; i++) begin
            tick(1);
            if (!key_held) held_ok = 1'b0;
        end
        keys[kidx(1, 3)] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (!key_held) held_ok = 1'b0;
        end
        check("t5_held_thru_drop", {31'd0, held_ok}, 32'd1);
        keys = 16'h0000;
        tick(160);
        check("t5_released", {31'd0, key_held}, 32'd0);
        check("t5_code_kept", {28'd0, key_code}, 32'hF);

        // 6. reset in the middle of a held 0
        keys[kidx(0, 3)] = 1'b1;
        push(4'h0, 64, 140);
        wait_valid(200);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_col_n", {28'd0, col_n}, 32'hE);
        check("t6_held", {31'd0, key_held}, 32'd0);
        check("t6_code", {28'd0, key_code}, 32'd0);
        check("t6_valid", {31'd0, key_valid}, 32'd0);
        push(4'h0, 96, 131);
        tick(200);
        check("t6_reheld", {31'd0, key_held}, 32'd1);
        keys = 16'h0000;
        tick(160);
        check("t6_released", {31'd0, key_held}, 32'd0);

        tick(5);
        check("sb_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
